// File: rtl/carry_forward_generator_pkg.sv
// Shared constants for the carry-forward generator.
//   GROUP_W    : bit width of one first-level lookahead group
//   num_groups : number of first-level groups for a given operand width
package carry_forward_generator_pkg;

  localparam int GROUP_W = 4;

  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/carry_forward_generator_cla4_cell.sv
// Combinational 4-bit lookahead cell. Each carry is a flattened
// sum-of-products, so no carry term waits on another.
// Ports:
//   g[3:0]  in   per-bit generate
//   p[3:0]  in   per-bit propagate
//   ci      in   carry into bit 0 of the group
//   c[4:1]  out  c[i] = carry out of bit i-1 of the group
//   gg      out  group generate (carry out with ci = 0)
//   gp      out  group propagate (&p)
module cla4_cell (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [4:1] c,
  output logic       gg,
  output logic       gp
);

  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/carry_forward_generator.sv
// Registered two-level carry-lookahead generator for a WIDTH-bit slice.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   a, b, cin valid this cycle
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   out_valid  out  registered results are valid
//   cout       out  cout[i] = carry out of bit i
//   p          out  per-bit propagate a ^ b
//   gg         out  slice group generate (final carry with cin = 0)
//   gp         out  slice group propagate (&p)
module carry_forward_generator
  import carry_forward_generator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] p,
  output logic             gg,
  output logic             gp
);

  localparam int NG = num_groups(WIDTH);

  if ((WIDTH < GROUP_W) || ((WIDTH % GROUP_W) != 0)) begin : g_width_check
    $error("carry_forward_generator: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] c_next;
  logic [NG-1:0]    grp_gg;
  logic [NG-1:0]    grp_gp;
  logic [NG-1:0]    grp_ci;
  logic             slice_gg;

  // Carry out of groups 0..k-1, flattened: every term is an independent
  // product of one group generate (or c0) with the propagates above it.
  function automatic logic lookahead(input logic [NG-1:0] ggv,
                                     input logic [NG-1:0] gpv,
                                     input logic          c0,
                                     input int            k);
    logic res;
    logic term;
    res = 1'b0;
    for (int j = 0; j < k; j++) begin
      term = ggv[j];
      for (int m = j + 1; m < k; m++) term = term & gpv[m];
      res = res | term;
    end
    term = c0;
    for (int m = 0; m < k; m++) term = term & gpv[m];
    return res | term;
  endfunction

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    assign grp_ci[k] = lookahead(grp_gg, grp_gp, cin, k);

    cla4_cell u_cla4_cell (
      .g  (g_bit[GROUP_W*k +: GROUP_W]),
      .p  (p_bit[GROUP_W*k +: GROUP_W]),
      .ci (grp_ci[k]),
      .c  (c_next[GROUP_W*k +: GROUP_W]),
      .gg (grp_gg[k]),
      .gp (grp_gp[k])
    );
  end

  assign slice_gg = lookahead(grp_gg, grp_gp, 1'b0, NG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cout      <= '0;
      p         <= '0;
      gg        <= 1'b0;
      gp        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        cout <= c_next;
        p    <= p_bit;
        gg   <= slice_gg;
        gp   <= &p_bit;
      end
    end
  end

endmodule

// File: tb/tb_carry_forward_generator.sv
module tb_carry_forward_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v4, cin4, ov4, gg4, gp4;
  logic [3:0]  a4, b4, co4, p4;
  logic        v16, cin16, ov16, gg16, gp16;
  logic [15:0] a16, b16, co16, p16;

  int checks = 0;
  int failures = 0;

  carry_forward_generator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .cout(co4), .p(p4), .gg(gg4), .gp(gp4)
  );

  carry_forward_generator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .cout(co16), .p(p16), .gg(gg16), .gp(gp16)
  );

  // Bit-serial addition: carry out of each column of a+b+cin, and the
  // same chain with cin = 0 for the group generate.
  function automatic void ref_add(input int w, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin,
                                  output logic [15:0] cout, output logic [15:0] p,
                                  output logic gg, output logic gp);
    int c, c0, s, s0;
    c = int'(cin);
    c0 = 0;
    cout = '0;
    p = '0;
    gp = 1'b1;
    for (int i = 0; i < w; i++) begin
      s  = int'(a[i]) + int'(b[i]) + c;
      s0 = int'(a[i]) + int'(b[i]) + c0;
      cout[i] = (s >= 2);
      p[i] = ((int'(a[i]) + int'(b[i])) == 1);
      gp = gp & p[i];
      c = s / 2;
      c0 = s0 / 2;
    end
    gg = (c0 == 1);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h1234; cin16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov4, co4, p4, gg4, gp4} !== 11'b0) begin
      failures++;
      $display("FAIL reset4 got ov=%b cout=%b p=%b gg=%b gp=%b want all 0",
               ov4, co4, p4, gg4, gp4);
    end
    checks++;
    if ({ov16, co16, p16, gg16, gp16} !== 35'b0) begin
      failures++;
      $display("FAIL reset16 got ov=%b cout=%h p=%h gg=%b gp=%b want all 0",
               ov16, co16, p16, gg16, gp16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b0;
    v16 = 1'b0;
  endtask

  logic [3:0] va [5] = '{4'b1110, 4'b1001, 4'b0110, 4'b0111, 4'b1111};
  logic [3:0] vb [5] = '{4'b0111, 4'b1101, 4'b1100, 4'b1110, 4'b0000};
  logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] ec [5] = '{4'b1110, 4'b1001, 4'b1100, 4'b1111, 4'b1111};
  logic [3:0] ep [5] = '{4'b1001, 4'b0100, 4'b1010, 4'b1001, 4'b1111};

  task automatic test_directed();
    logic [15:0] mc, mp;
    logic mgg, mgp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v4 = 1'b1; a4 = va[k]; b4 = vb[k]; cin4 = vc[k];
      @(negedge clk);
      v4 = 1'b0;
      #1;
      ref_add(4, {12'b0, va[k]}, {12'b0, vb[k]}, vc[k], mc, mp, mgg, mgp);
      checks++;
      if (ov4 !== 1'b1 || co4 !== ec[k] || p4 !== ep[k]) begin
        failures++;
        $display("FAIL directed%0d got ov=%b cout=%b p=%b want ov=1 cout=%b p=%b",
                 k, ov4, co4, p4, ec[k], ep[k]);
      end
      checks++;
      if (gg4 !== mgg || gp4 !== mgp) begin
        failures++;
        $display("FAIL directed_grp%0d got gg=%b gp=%b want gg=%b gp=%b",
                 k, gg4, gp4, mgg, mgp);
      end
    end
    // Full propagate chain: gp=1, gg=0 are fixed by the operands.
    checks++;
    if (gp4 !== 1'b1 || gg4 !== 1'b0) begin
      failures++;
      $display("FAIL boundary_chain got gg=%b gp=%b want gg=0 gp=1", gg4, gp4);
    end
    @(negedge clk);
    v4 = 1'b1; a4 = 4'b0000; b4 = 4'b0000; cin4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    checks++;
    if (co4 !== 4'b0000 || p4 !== 4'b0000 || gp4 !== 1'b0) begin
      failures++;
      $display("FAIL boundary_zero got cout=%b p=%b gp=%b want cout=0000 p=0000 gp=0",
               co4, p4, gp4);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v4 = 1'b1; a4 = va[k]; b4 = vb[k]; cin4 = vc[k];
      @(posedge clk);
      #1;
      checks++;
      if (ov4 !== 1'b1 || co4 !== ec[k] || p4 !== ep[k]) begin
        failures++;
        $display("FAIL b2b%0d got ov=%b cout=%b p=%b want ov=1 cout=%b p=%b",
                 k, ov4, co4, p4, ec[k], ep[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (ov4 !== 1'b0 || co4 !== ec[3] || p4 !== ep[3]) begin
        failures++;
        $display("FAIL hold%0d got ov=%b cout=%b p=%b want ov=0 cout=%b p=%b",
                 k, ov4, co4, p4, ec[3], ep[3]);
      end
    end
    @(negedge clk);
    v4 = 1'b1; a4 = 4'b1111; b4 = 4'b0001; cin4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ov4, co4, p4, gg4, gp4} !== 11'b0) begin
      failures++;
      $display("FAIL midreset got ov=%b cout=%b p=%b gg=%b gp=%b want all 0",
               ov4, co4, p4, gg4, gp4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] mc, mp, e_c4, e_p4, e_c16, e_p16;
    logic mgg, mgp, e_gg4, e_gp4, e_gg16, e_gp16, e_ov4, e_ov16;
    e_c4 = '0; e_p4 = '0; e_gg4 = 1'b0; e_gp4 = 1'b0;
    e_c16 = '0; e_p16 = '0; e_gg16 = 1'b0; e_gp16 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      v4 = ($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      v16 = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      if (n % 25 == 0) begin
        a16 = ~b16;
      end
      e_ov4 = v4;
      e_ov16 = v16;
      if (v4) begin
        ref_add(4, {12'b0, a4}, {12'b0, b4}, cin4, mc, mp, mgg, mgp);
        e_c4 = mc; e_p4 = mp; e_gg4 = mgg; e_gp4 = mgp;
      end
      if (v16) begin
        ref_add(16, a16, b16, cin16, mc, mp, mgg, mgp);
        e_c16 = mc; e_p16 = mp; e_gg16 = mgg; e_gp16 = mgp;
      end
      @(posedge clk);
      #1;
      checks++;
      if (ov4 !== e_ov4 || co4 !== e_c4[3:0] || p4 !== e_p4[3:0]
          || gg4 !== e_gg4 || gp4 !== e_gp4) begin
        failures++;
        $display("FAIL rand4_%0d got ov=%b cout=%b p=%b gg=%b gp=%b want ov=%b cout=%b p=%b gg=%b gp=%b",
                 n, ov4, co4, p4, gg4, gp4, e_ov4, e_c4[3:0], e_p4[3:0], e_gg4, e_gp4);
      end
      checks++;
      if (ov16 !== e_ov16 || co16 !== e_c16 || p16 !== e_p16
          || gg16 !== e_gg16 || gp16 !== e_gp16) begin
        failures++;
        $display("FAIL rand16_%0d got ov=%b cout=%h p=%h gg=%b gp=%b want ov=%b cout=%h p=%h gg=%b gp=%b",
                 n, ov16, co16, p16, gg16, gp16, e_ov16, e_c16, e_p16, e_gg16, e_gp16);
      end
    end
    @(negedge clk);
    v4 = 1'b0;
    v16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
